// File: rtl/edit_mem_buf_free_list_pkg.sv
// Shared definitions for the edit-memory buffer free list.
// EM_FREE_LIST_DUP_CHECK_EN adds the duplicate-release error bit.
`ifndef EM_BUF_PTR_NBITS
`define EM_BUF_PTR_NBITS 3
`endif

package edit_mem_buf_free_list_pkg;

   localparam int EM_BUF_PTR_NBITS = `EM_BUF_PTR_NBITS;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } fl_state_e;

   localparam int ERR_OVERFLOW_BIT  = 0;
   localparam int ERR_UNDERFLOW_BIT = 1;
`ifdef EM_FREE_LIST_DUP_CHECK_EN
   localparam int ERR_DUP_REL_BIT   = 2;
   localparam int ERR_NBITS         = 3;
`else
   localparam int ERR_NBITS         = 2;
`endif

endpackage

// File: rtl/edit_mem_free_prefetch.sv
// Two-entry show-ahead queue in front of the free-list RAM. A read that has
// been issued but not yet returned reserves a slot, so the queue never overfills.
module edit_mem_free_prefetch #(
   parameter int PTR_NBITS = 3
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 ram_avail,
   input  logic                 pop,
   input  logic [PTR_NBITS-1:0] rd_data,
   output logic                 rd_issue,
   output logic                 valid,
   output logic [PTR_NBITS-1:0] ptr,
   output logic [1:0]           occupancy
);

   logic [PTR_NBITS-1:0] q0, q1, q0_nxt, q1_nxt;
   logic [1:0]           q_count, q_count_nxt, cnt_after_pop;
   logic                 in_flight;

   // NOTE: every always_comb output gets a default first, so no latch is inferred.
   always_comb begin
      q0_nxt        = q0;
      q1_nxt        = q1;
      cnt_after_pop = q_count - {1'b0, pop};
      if (pop) begin
         q0_nxt = q1;
      end
      if (in_flight) begin
         if (cnt_after_pop == 2'd0) begin
            q0_nxt = rd_data;
         end else begin
            q1_nxt = rd_data;
         end
      end
      q_count_nxt = cnt_after_pop + {1'b0, in_flight};
      // Counting the slot freed by this cycle's pop keeps one pop per cycle sustainable.
      rd_issue    = ram_avail && (q_count_nxt < 2'd2);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         q0        <= '0;
         q1        <= '0;
         q_count   <= '0;
         in_flight <= 1'b0;
      end else begin
         q0        <= q0_nxt;
         q1        <= q1_nxt;
         q_count   <= q_count_nxt;
         in_flight <= rd_issue;
      end
   end

   assign valid     = (q_count != 2'd0);
   assign ptr       = q0;
   assign occupancy = q_count + {1'b0, in_flight};

endmodule

// File: rtl/ram_1r1w_ultra.sv
// Simple dual-port RAM: one write port, one registered read port.
// A read of the address being written in the same cycle returns the new data.
module ram_1r1w_ultra #(
   parameter int DATA_NBITS = 8,
   parameter int ADDR_NBITS = 3,
   parameter int DEPTH      = 1 << ADDR_NBITS
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_NBITS-1:0] waddr,
   input  logic [DATA_NBITS-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_NBITS-1:0] raddr,
   output logic [DATA_NBITS-1:0] rdata
);

   logic [DATA_NBITS-1:0] mem [DEPTH];

   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   // NOTE: the array has no reset; every entry is written before it is read.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
      end
   end

endmodule

// File: rtl/edit_mem_buf_free_list.sv
// Free list of edit-memory buffer pointers: RAM-backed circular FIFO with a
// show-ahead prefetch queue. EM_FREE_LIST_DUP_CHECK_EN adds an in-use bitmap.
module edit_mem_buf_free_list
   import edit_mem_buf_free_list_pkg::*;
#(
   parameter int BPTR_NBITS = EM_BUF_PTR_NBITS,
   parameter int NUM_BUFS   = 1 << BPTR_NBITS,
   parameter int CNT_NBITS  = BPTR_NBITS + 1
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  rel_buf_valid,
   input  logic [BPTR_NBITS-1:0] rel_buf_ptr,
   input  logic                  alloc_rd,
   output logic                  alloc_valid,
   output logic [BPTR_NBITS-1:0] alloc_ptr,
   output logic                  init_read_count_valid,
   output logic [BPTR_NBITS-1:0] init_read_count_ptr,
   output logic [CNT_NBITS-1:0]  free_count,
   output logic                  init_done,
   output logic                  err_overflow,
   output logic                  err_underflow
`ifdef EM_FREE_LIST_DUP_CHECK_EN
   ,
   output logic                  err_dup_rel
`endif
);

   localparam logic [BPTR_NBITS-1:0] LAST_PTR = BPTR_NBITS'(NUM_BUFS - 1);
   localparam logic [CNT_NBITS-1:0]  FULL_CNT = CNT_NBITS'(NUM_BUFS);

   fl_state_e             state, state_nxt;
   logic [BPTR_NBITS-1:0] head, tail;
   logic [ERR_NBITS-1:0]  err, err_set;
   logic                  pop, rel_accept, init_last;
   logic                  ram_we, ram_avail, rd_issue;
   logic [BPTR_NBITS-1:0] ram_wdata, rd_data;
   logic [1:0]            pf_occupancy;
`ifdef EM_FREE_LIST_DUP_CHECK_EN
   logic [NUM_BUFS-1:0]   in_use;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= INIT;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      ram_we     = 1'b0;
      ram_wdata  = tail;
      rel_accept = 1'b0;
      init_last  = 1'b0;
      err_set    = '0;
      pop        = alloc_rd && alloc_valid;
      err_set[ERR_UNDERFLOW_BIT] = alloc_rd && !alloc_valid;
      case (state)
         INIT: begin
            // Fill phase: tail doubles as the pointer value written to RAM[tail].
            ram_we = 1'b1;
            err_set[ERR_OVERFLOW_BIT] = rel_buf_valid;
            if (tail == LAST_PTR) begin
               init_last = 1'b1;
               state_nxt = READY;
            end
         end
         READY: begin
            if (rel_buf_valid) begin
               if (free_count == FULL_CNT) begin
                  err_set[ERR_OVERFLOW_BIT] = 1'b1;
`ifdef EM_FREE_LIST_DUP_CHECK_EN
               end else if (!in_use[rel_buf_ptr]) begin
                  err_set[ERR_DUP_REL_BIT] = 1'b1;
`endif
               end else begin
                  rel_accept = 1'b1;
               end
            end
            ram_we    = rel_accept;
            ram_wdata = rel_buf_ptr;
         end
      endcase
   end

   // Entries still in RAM = all free pointers minus those queued or in flight.
   assign ram_avail = (state == READY) && (free_count > CNT_NBITS'(pf_occupancy));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         head                  <= '0;
         tail                  <= '0;
         free_count            <= '0;
         init_done             <= 1'b0;
         err                   <= '0;
         init_read_count_valid <= 1'b0;
         init_read_count_ptr   <= '0;
      end else begin
         err                   <= err | err_set;
         init_read_count_valid <= pop;
         if (pop) begin
            init_read_count_ptr <= alloc_ptr;
         end
         if (ram_we) begin
            tail <= (tail == LAST_PTR) ? '0 : tail + 1'b1;
         end
         if (rd_issue) begin
            head <= (head == LAST_PTR) ? '0 : head + 1'b1;
         end
         if (init_last) begin
            free_count <= FULL_CNT;
            init_done  <= 1'b1;
         end else begin
            free_count <= free_count + CNT_NBITS'(rel_accept) - CNT_NBITS'(pop);
         end
      end
   end

`ifdef EM_FREE_LIST_DUP_CHECK_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         in_use <= '0;
      end else begin
         if (pop) begin
            in_use[alloc_ptr] <= 1'b1;
         end
         if (rel_accept) begin
            in_use[rel_buf_ptr] <= 1'b0;
         end
      end
   end

   assign err_dup_rel = err[ERR_DUP_REL_BIT];
`endif

   assign err_overflow  = err[ERR_OVERFLOW_BIT];
   assign err_underflow = err[ERR_UNDERFLOW_BIT];

   ram_1r1w_ultra #(
      .DATA_NBITS (BPTR_NBITS),
      .ADDR_NBITS (BPTR_NBITS),
      .DEPTH      (NUM_BUFS)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (tail),
      .wdata (ram_wdata),
      .re    (rd_issue),
      .raddr (head),
      .rdata (rd_data)
   );

   edit_mem_free_prefetch #(
      .PTR_NBITS (BPTR_NBITS)
   ) u_prefetch (
      .clk       (clk),
      .rstn      (rstn),
      .ram_avail (ram_avail),
      .pop       (pop),
      .rd_data   (rd_data),
      .rd_issue  (rd_issue),
      .valid     (alloc_valid),
      .ptr       (alloc_ptr),
      .occupancy (pf_occupancy)
   );

endmodule

// File: tb/tb_edit_mem_buf_free_list.sv
// Bench for edit_mem_buf_free_list with 8 buffers: directed scenarios plus a
// randomized run against a pointer-FIFO reference model.
module tb_edit_mem_buf_free_list;

   localparam int BPTR = 3;
   localparam int NB   = 8;
   localparam int CNTW = 4;

   logic            clk = 1'b0;
   logic            rstn = 1'b0;
   logic            rel_buf_valid = 1'b0;
   logic [BPTR-1:0] rel_buf_ptr = '0;
   logic            alloc_rd = 1'b0;
   logic            alloc_valid;
   logic [BPTR-1:0] alloc_ptr;
   logic            init_read_count_valid;
   logic [BPTR-1:0] init_read_count_ptr;
   logic [CNTW-1:0] free_count;
   logic            init_done;
   logic            err_overflow;
   logic            err_underflow;
`ifdef EM_FREE_LIST_DUP_CHECK_EN
   logic            err_dup_rel;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   edit_mem_buf_free_list #(
      .BPTR_NBITS (BPTR),
      .NUM_BUFS   (NB),
      .CNT_NBITS  (CNTW)
   ) dut (
      .clk                   (clk),
      .rstn                  (rstn),
      .rel_buf_valid         (rel_buf_valid),
      .rel_buf_ptr           (rel_buf_ptr),
      .alloc_rd              (alloc_rd),
      .alloc_valid           (alloc_valid),
      .alloc_ptr             (alloc_ptr),
      .init_read_count_valid (init_read_count_valid),
      .init_read_count_ptr   (init_read_count_ptr),
      .free_count            (free_count),
      .init_done             (init_done),
      .err_overflow          (err_overflow),
`ifdef EM_FREE_LIST_DUP_CHECK_EN
      .err_dup_rel           (err_dup_rel),
`endif
      .err_underflow         (err_underflow)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string name);
      int n = 0;
      while (!(init_done && alloc_valid) && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (!(init_done && alloc_valid) || alloc_ptr !== 3'd0 || free_count !== 4'd8) begin
         errors++;
         $display("FAIL %s: init_done=%0b alloc_valid=%0b alloc_ptr=%0d free_count=%0d, expected 1 1 0 8",
                  name, init_done, alloc_valid, alloc_ptr, free_count);
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      tick();
      tick();
      checks++;
      if ({alloc_valid, init_read_count_valid, init_done, err_overflow, err_underflow} !== 5'b0 ||
          alloc_ptr !== '0 || init_read_count_ptr !== '0 || free_count !== '0) begin
         errors++;
         $display("FAIL reset_outputs: valid=%0b irc=%0b done=%0b ovf=%0b udf=%0b ptr=%0d cnt=%0d, expected all 0",
                  alloc_valid, init_read_count_valid, init_done, err_overflow, err_underflow, alloc_ptr, free_count);
      end
      rstn = 1'b1;
      for (int i = 1; i <= NB; i++) begin
         tick();
         checks++;
         if (init_done !== (i == NB) || alloc_valid !== 1'b0) begin
            errors++;
            $display("FAIL init_fill[%0d]: init_done=%0b alloc_valid=%0b, expected %0b 0",
                     i, init_done, alloc_valid, (i == NB));
         end
      end
      checks++;
      if (free_count !== 4'd8) begin
         errors++;
         $display("FAIL init_free_count: got %0d expected 8", free_count);
      end
      tick();
      checks++;
      if (alloc_valid !== 1'b0) begin
         errors++;
         $display("FAIL first_alloc_early: alloc_valid=%0b expected 0", alloc_valid);
      end
      tick();
      checks++;
      if (alloc_valid !== 1'b1 || alloc_ptr !== 3'd0) begin
         errors++;
         $display("FAIL first_alloc: alloc_valid=%0b alloc_ptr=%0d expected 1 0", alloc_valid, alloc_ptr);
      end
   endtask

   task automatic test_overflow_full();
      rel_buf_valid = 1'b1;
      rel_buf_ptr   = 3'd3;
      tick();
      rel_buf_valid = 1'b0;
      checks++;
      if (err_overflow !== 1'b1 || free_count !== 4'd8) begin
         errors++;
         $display("FAIL overflow_full: err_overflow=%0b free_count=%0d expected 1 8", err_overflow, free_count);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < NB; i++) begin
         checks++;
         if (alloc_valid !== 1'b1 || alloc_ptr !== BPTR'(i)) begin
            errors++;
            $display("FAIL b2b_present[%0d]: alloc_valid=%0b alloc_ptr=%0d expected 1 %0d", i, alloc_valid, alloc_ptr, i);
         end
         alloc_rd = 1'b1;
         tick();
         checks++;
         if (init_read_count_valid !== 1'b1 || init_read_count_ptr !== BPTR'(i) || free_count !== CNTW'(NB - 1 - i)) begin
            errors++;
            $display("FAIL b2b_pop[%0d]: irc_valid=%0b irc_ptr=%0d free_count=%0d expected 1 %0d %0d",
                     i, init_read_count_valid, init_read_count_ptr, free_count, i, NB - 1 - i);
         end
      end
      alloc_rd = 1'b0;
      checks++;
      if (alloc_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_empty: alloc_valid=%0b expected 0", alloc_valid);
      end
      tick();
      checks++;
      if (init_read_count_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_pulse_end: irc_valid=%0b expected 0", init_read_count_valid);
      end
   endtask

   task automatic test_release_latency();
      rel_buf_valid = 1'b1;
      rel_buf_ptr   = 3'd5;
      tick();
      rel_buf_valid = 1'b0;
      checks++;
      if (alloc_valid !== 1'b0 || free_count !== 4'd1) begin
         errors++;
         $display("FAIL rel_lat_write: alloc_valid=%0b free_count=%0d expected 0 1", alloc_valid, free_count);
      end
      tick();
      checks++;
      if (alloc_valid !== 1'b0) begin
         errors++;
         $display("FAIL rel_lat_read: alloc_valid=%0b expected 0", alloc_valid);
      end
      tick();
      checks++;
      if (alloc_valid !== 1'b1 || alloc_ptr !== 3'd5 || free_count !== 4'd1) begin
         errors++;
         $display("FAIL rel_lat_queue: alloc_valid=%0b alloc_ptr=%0d free_count=%0d expected 1 5 1",
                  alloc_valid, alloc_ptr, free_count);
      end
   endtask

   task automatic test_simultaneous();
      rel_buf_valid = 1'b1;
      rel_buf_ptr   = 3'd2;
      alloc_rd      = 1'b1;
      tick();
      rel_buf_valid = 1'b0;
      alloc_rd      = 1'b0;
      checks++;
      if (free_count !== 4'd1 || init_read_count_valid !== 1'b1 || init_read_count_ptr !== 3'd5) begin
         errors++;
         $display("FAIL simul_pop: free_count=%0d irc_valid=%0b irc_ptr=%0d expected 1 1 5",
                  free_count, init_read_count_valid, init_read_count_ptr);
      end
      tick();
      tick();
      checks++;
      if (alloc_valid !== 1'b1 || alloc_ptr !== 3'd2 || free_count !== 4'd1) begin
         errors++;
         $display("FAIL simul_return: alloc_valid=%0b alloc_ptr=%0d free_count=%0d expected 1 2 1",
                  alloc_valid, alloc_ptr, free_count);
      end
   endtask

   task automatic test_underflow();
      alloc_rd = 1'b1;
      tick();
      alloc_rd = 1'b0;
      checks++;
      if (free_count !== 4'd0 || alloc_valid !== 1'b0 || init_read_count_ptr !== 3'd2 || err_underflow !== 1'b0) begin
         errors++;
         $display("FAIL underflow_setup: free_count=%0d alloc_valid=%0b irc_ptr=%0d udf=%0b expected 0 0 2 0",
                  free_count, alloc_valid, init_read_count_ptr, err_underflow);
      end
      alloc_rd = 1'b1;
      tick();
      alloc_rd = 1'b0;
      checks++;
      if (err_underflow !== 1'b1 || free_count !== 4'd0 || init_read_count_valid !== 1'b0) begin
         errors++;
         $display("FAIL underflow: udf=%0b free_count=%0d irc_valid=%0b expected 1 0 0",
                  err_underflow, free_count, init_read_count_valid);
      end
   endtask

   task automatic test_reset_mid();
      rstn = 1'b0;
      #2;
      checks++;
      if (free_count !== '0 || err_underflow !== 1'b0 || err_overflow !== 1'b0 || init_done !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: free_count=%0d udf=%0b ovf=%0b done=%0b expected 0 0 0 0",
                  free_count, err_underflow, err_overflow, init_done);
      end
      rstn          = 1'b1;
      rel_buf_valid = 1'b1;
      rel_buf_ptr   = 3'd6;
      tick();
      rel_buf_valid = 1'b0;
      checks++;
      if (err_overflow !== 1'b1 || init_done !== 1'b0) begin
         errors++;
         $display("FAIL init_release: err_overflow=%0b init_done=%0b expected 1 0", err_overflow, init_done);
      end
      wait_ready("mid_reset_rebuild");
   endtask

   task automatic test_random();
      logic [BPTR-1:0] model_q[$];
      logic [NB-1:0]   out_mask = '0;
      logic            exp_ovf = 1'b1;
`ifdef EM_FREE_LIST_DUP_CHECK_EN
      logic            exp_dup = 1'b0;
`endif
      logic [BPTR-1:0] rptr, popped;
      logic            do_pop, do_rel, acc;
      int              starve = 0;
      for (int i = 0; i < NB; i++) model_q.push_back(BPTR'(i));
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (alloc_valid) begin
            checks++;
            if (model_q.size() == 0 || alloc_ptr !== model_q[0]) begin
               errors++;
               $display("FAIL rand_alloc_ptr[%0d]: got %0d expected %0d (model size %0d)",
                        cyc, alloc_ptr, (model_q.size() != 0) ? model_q[0] : '0, model_q.size());
            end
         end
         starve = (model_q.size() != 0 && !alloc_valid) ? starve + 1 : 0;
         if (model_q.size() != 0) begin
            checks++;
            if (starve > 3) begin
               errors++;
               $display("FAIL rand_starve[%0d]: alloc_valid=0 for %0d cycles, expected at most 3", cyc, starve);
               starve = 0;
            end
         end
         do_pop = alloc_valid && ($urandom_range(0, 2) != 0);
         do_rel = 1'b0;
         rptr   = '0;
         if ($urandom_range(0, 1) == 1) begin
            if (out_mask != '0) begin
               do begin
                  rptr = BPTR'($urandom_range(0, NB - 1));
               end while (!out_mask[rptr]);
               do_rel = 1'b1;
            end else if ($urandom_range(0, 7) == 0) begin
               rptr   = BPTR'($urandom_range(0, NB - 1));
               do_rel = 1'b1;
            end
         end
         alloc_rd      = do_pop;
         rel_buf_valid = do_rel;
         rel_buf_ptr   = rptr;
         tick();
         alloc_rd      = 1'b0;
         rel_buf_valid = 1'b0;
         acc = do_rel && (model_q.size() < NB);
         if (do_rel && model_q.size() == NB) exp_ovf = 1'b1;
`ifdef EM_FREE_LIST_DUP_CHECK_EN
         if (acc && !out_mask[rptr]) begin
            acc     = 1'b0;
            exp_dup = 1'b1;
         end
`endif
         popped = '0;
         if (do_pop) begin
            popped           = model_q.pop_front();
            out_mask[popped] = 1'b1;
         end
         if (acc) begin
            model_q.push_back(rptr);
            out_mask[rptr] = 1'b0;
         end
         checks++;
         if (free_count !== CNTW'(model_q.size()) || init_read_count_valid !== do_pop ||
             (do_pop && init_read_count_ptr !== popped) || err_overflow !== exp_ovf) begin
            errors++;
            $display("FAIL rand_state[%0d]: cnt=%0d irc=%0b/%0d ovf=%0b expected cnt=%0d irc=%0b/%0d ovf=%0b",
                     cyc, free_count, init_read_count_valid, init_read_count_ptr, err_overflow,
                     model_q.size(), do_pop, popped, exp_ovf);
         end
      end
      checks++;
      if (err_underflow !== 1'b0) begin
         errors++;
         $display("FAIL rand_underflow: err_underflow=%0b expected 0", err_underflow);
      end
`ifdef EM_FREE_LIST_DUP_CHECK_EN
      checks++;
      if (err_dup_rel !== exp_dup) begin
         errors++;
         $display("FAIL rand_dup: err_dup_rel=%0b expected %0b", err_dup_rel, exp_dup);
      end
`endif
   endtask

`ifdef EM_FREE_LIST_DUP_CHECK_EN
   task automatic test_dup_release();
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      wait_ready("dup_rebuild");
      alloc_rd = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      alloc_rd = 1'b0;
      rel_buf_valid = 1'b1;
      rel_buf_ptr   = 3'd4;
      tick();
      checks++;
      if (free_count !== 4'd4 || err_dup_rel !== 1'b0) begin
         errors++;
         $display("FAIL dup_first: free_count=%0d err_dup_rel=%0b expected 4 0", free_count, err_dup_rel);
      end
      tick();
      rel_buf_valid = 1'b0;
      checks++;
      if (free_count !== 4'd4 || err_dup_rel !== 1'b1 || err_overflow !== 1'b0) begin
         errors++;
         $display("FAIL dup_second: free_count=%0d err_dup_rel=%0b ovf=%0b expected 4 1 0",
                  free_count, err_dup_rel, err_overflow);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_overflow_full();
      test_back_to_back();
      test_release_latency();
      test_simultaneous();
      test_underflow();
      test_reset_mid();
      test_random();
`ifdef EM_FREE_LIST_DUP_CHECK_EN
      test_dup_release();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/edit_mem_buf_free_list.md
Name: edit_mem_buf_free_list

Overview:
- Owns the pool of free edit-memory buffer pointers.
- Sits directly downstream of the buffer-release stage: consumes its rel_buf_valid/rel_buf_ptr stream and pushes those pointers back onto the free list.
- Hands free pointers to the edit-memory writer, and pulses init_read_count_valid/ptr back to the release stage so that buffer's release counter is cleared on allocation.
- Free list is a RAM-backed circular FIFO, filled with every pointer after reset.

Parameters:
- BPTR_NBITS, `EM_BUF_PTR_NBITS, buffer pointer width.
- NUM_BUFS, (1<<BPTR_NBITS), number of managed buffers; legal range is 2 to 2^BPTR_NBITS.
- CNT_NBITS, BPTR_NBITS+1, width of the occupancy counter.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset (the codebase `RESET_SIG); asynchronous, active-low.
- rel_buf_valid  in  1  released pointer valid.
- rel_buf_ptr  in  BPTR_NBITS  released pointer.
- alloc_rd  in  1  pop the pointer on alloc_ptr; legal only while alloc_valid=1.
- alloc_valid  out  1  a free pointer is presented.
- alloc_ptr  out  BPTR_NBITS  presented free pointer (show-ahead).
- init_read_count_valid  out  1  one-cycle pulse, one cycle after a legal pop.
- init_read_count_ptr  out  BPTR_NBITS  the popped pointer.
- free_count  out  CNT_NBITS  free pointers held, prefetched entries included.
- init_done  out  1  initial fill complete.
- err_overflow  out  1  sticky: release dropped (list full or INIT).
- err_underflow  out  1  sticky: alloc_rd asserted with alloc_valid=0.

Behaviour:
- Reset values: every output is 0; head=tail=0; FSM=INIT.
- INIT state:
  - Writes pointer i into RAM[i], one per cycle, for i=0..NUM_BUFS-1.
  - The last write sets tail=0 (wrapped), free_count=NUM_BUFS and init_done=1, then enters READY.
  - alloc_valid stays 0 during INIT.
  - rel_buf_valid during INIT is dropped and sets err_overflow.
- READY state: absorbing; left only by reset.
- Storage:
  - RAM is 1R1W with 1-cycle read latency.
  - head and tail wrap from NUM_BUFS-1 to 0.
- Prefetch queue (2 entries) feeds alloc_ptr:
  - When the queue is not full and RAM holds entries not yet prefetched, a RAM read is issued and head advances.
  - Read data enters the queue the next cycle.
  - An in-flight read counts against queue capacity.
  - The queue sustains one pop per cycle.
- Latency:
  - First alloc_valid appears 2 cycles after INIT exits.
  - With the list empty, a release reaches alloc_ptr 3 cycles later: RAM write, read, queue.
- Release path:
  - rel_buf_valid with free_count<NUM_BUFS writes RAM[tail] and increments tail.
  - rel_buf_valid with free_count==NUM_BUFS is dropped and sets err_overflow.
  - A RAM read of the address being written in the same cycle returns the new data (write-first bypass).
- free_count:
  - +1 on an accepted release, -1 on a legal pop.
  - Simultaneous accepted release and legal pop leave it unchanged.
  - Never wraps.
- Illegal pop: alloc_rd with alloc_valid=0 is ignored (no state change) and sets err_underflow.
- Reset mid-operation: returns to INIT and the whole pool is rebuilt. Buffers outstanding at reset are forgotten.

Optional Feature:
- Macro: EM_FREE_LIST_DUP_CHECK_EN.
- Defined:
  - An in-use bitmap of NUM_BUFS bits is kept: set on pop, cleared on accepted release.
  - A release of a pointer whose bit is 0 is dropped (free_count unchanged) and asserts a sticky output err_dup_rel.
  - All bits are 0 after reset.
- Not defined: no bitmap and no err_dup_rel port; every release under capacity is accepted.

Decomposition:
- Shared package/defines file holds:
  - EM_BUF_PTR_NBITS.
  - FSM state encoding: INIT=1'b0, READY=1'b1.
  - Error bit positions.
- Natural sub-module: edit_mem_free_prefetch, the 2-entry show-ahead queue with in-flight read tracking.
- RAM uses the existing ram_1r1w_ultra.

Test Plan:
- Reset, NUM_BUFS=8 → init_done rises after 8 cycles; alloc_valid 2 cycles later with alloc_ptr=0; free_count=8.
- alloc_rd held for 8 cycles → ptrs 0..7 back-to-back; init_read_count pulses each ptr 1 cycle later; free_count 0; alloc_valid drops.
- List empty, release ptr 5 → alloc_valid=1, alloc_ptr=5 three cycles later; free_count=1.
- List full, release ptr 3 → dropped; err_overflow=1; free_count stays 8.
- Same-cycle release of ptr 2 and pop → free_count unchanged; ptr 2 returns after the wrap order.
- EM_FREE_LIST_DUP_CHECK_EN defined, release ptr 4 twice after a single pop → second release dropped; err_dup_rel=1.
